// File: rtl/wb_dma_pkg.sv
// Shared definitions for the Wishbone block-copy engine: FSM encoding and
// bus constants.
package wb_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } dma_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [3:0] WB_SEL_ALL  = 4'b1111;

endpackage

// File: rtl/wb_dma_buf.sv
// Burst buffer: synchronous FIFO holding the words of one read burst until
// they are written back out. Read data is the current head (no latency), so a
// pop exposes the next word in the following cycle.
module wb_dma_buf
    import wb_dma_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    // Pointer and fill-level update; DEPTH is a power of two so pointers wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_i);
        level_d  = level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end

    // Pointer/level registers; reset empties the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because level gates validity.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Never overfilled or drained past empty: the controller sizes bursts to DEPTH.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && !pop_i && level_q == (AW+1)'(DEPTH)));
            assert (!(pop_i && level_q == '0));
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/wb_dma_copy.sv
// Pipelined Wishbone block-copy engine. Copies len_i words from src to dst in
// chunks of at most BURST_LEN: read a chunk into the buffer, write it out,
// advance, repeat. cyc drops for at least one cycle between every burst.
// Handshake: a request is accepted on a cycle with stb=1 and stall=0; each
// accepted request receives exactly one ack, in order, possibly in the same
// cycle as its acceptance.
module wb_dma_copy
    import wb_dma_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int LEN_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      wb_addr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic [2:0]       wb_cti_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    input  logic             wb_stall_i,
    input  logic             wb_ack_i
);

    localparam int CW = $clog2(BURST_LEN) + 1;

    dma_state_e       state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d, addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CW-1:0]    req_cnt_q, req_cnt_d, ack_cnt_q, ack_cnt_d, outst_q, outst_d;

    logic [CW-1:0]    burst_w;
    logic             active, cyc, stb, accept, ack_ok;
    logic             buf_push, buf_pop;
    logic [31:0]      buf_rdata;
    logic [CW-1:0]    buf_level;

    // Bus-phase decode: a burst owns the bus until all its acks are back,
    // and issues requests until all of its words have been accepted.
    always_comb begin
        burst_w = (rem_q >= LEN_W'(BURST_LEN)) ? CW'(BURST_LEN) : rem_q[CW-1:0];
        active  = (state_q == ST_READ) || (state_q == ST_WRITE);
        cyc     = active && (ack_cnt_q != burst_w);
        stb     = active && (req_cnt_q != burst_w);
        accept  = stb && !wb_stall_i;
        // A same-cycle ack may answer the request being accepted right now.
        ack_ok  = wb_ack_i && ((outst_q != '0) || accept);
        buf_push = ack_ok && (state_q == ST_READ);
        buf_pop  = accept && (state_q == ST_WRITE);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        req_cnt_d = req_cnt_q;
        ack_cnt_d = ack_cnt_q;
        outst_d   = outst_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_i & ~32'h3;
                    dst_d   = dst_addr_i & ~32'h3;
                    addr_d  = src_addr_i & ~32'h3;
                    rem_d   = len_i;
                    state_d = (len_i == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (accept) begin
                    req_cnt_d = req_cnt_q + CW'(1);
                    addr_d    = addr_q + 32'd4;
                end
                if (ack_ok) begin
                    ack_cnt_d = ack_cnt_q + CW'(1);
                end
                outst_d = outst_q + CW'(accept) - CW'(ack_ok);
                // cyc already low this cycle: burst complete, this is the gap.
                if (!cyc) begin
                    req_cnt_d = '0;
                    ack_cnt_d = '0;
                    if (state_q == ST_READ) begin
                        state_d = ST_WRITE;
                        addr_d  = dst_q;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                rem_d   = rem_q - LEN_W'(burst_w);
                src_d   = src_q + (32'(burst_w) << 2);
                dst_d   = dst_q + (32'(burst_w) << 2);
                addr_d  = src_d;
                state_d = (rem_d == '0) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight burst.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            req_cnt_q <= '0;
            ack_cnt_q <= '0;
            outst_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            req_cnt_q <= req_cnt_d;
            ack_cnt_q <= ack_cnt_d;
            outst_q   <= outst_d;
        end
    end

    // Stray acks are dropped by ack_ok; flag them so a broken responder is visible.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(wb_ack_i && !ack_ok));
            assert (!(buf_pop && buf_level == '0));
        end
    end

    wb_dma_buf #(
        .DEPTH (BURST_LEN),
        .W     (32)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (buf_push),
        .din_i   (wb_dat_i),
        .pop_i   (buf_pop),
        .dout_o  (buf_rdata),
        .level_o (buf_level)
    );

    assign busy_o    = (state_q == ST_READ) || (state_q == ST_WRITE) || (state_q == ST_NEXT);
    assign done_o    = (state_q == ST_DONE);
    assign wb_cyc_o  = cyc;
    assign wb_stb_o  = stb;
    assign wb_we_o   = cyc && (state_q == ST_WRITE);
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = (stb && state_q == ST_WRITE) ? buf_rdata : 32'h0;
    assign wb_sel_o  = stb ? WB_SEL_ALL : 4'b0000;
    assign wb_cti_o  = !stb ? CTI_CLASSIC :
                       (req_cnt_q == burst_w - CW'(1)) ? CTI_END : CTI_INCR;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Bench for wb_dma_copy: a pipelined Wishbone memory model with random stall
// and ack latency, and a scoreboard of expected read requests, write
// transactions and burst lengths derived from each copy request.
module tb_wb_dma_copy;

  localparam int BL = 8;
  localparam logic [2:0] C_INCR = 3'b010;
  localparam logic [2:0] C_END  = 3'b111;

  logic        clk_i = 0;
  logic        rst_i = 1;
  logic        start_i = 0;
  logic [31:0] src_addr_i = 0;
  logic [31:0] dst_addr_i = 0;
  logic [15:0] len_i = 0;
  logic        busy_o, done_o;
  logic [31:0] wb_addr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 0;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic        wb_stall_i = 0;
  logic        wb_ack_i = 0;

  wb_dma_copy #(.BURST_LEN(BL), .LEN_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i)
  );

  // clock
  always #5 clk_i = ~clk_i;

  // scoreboard state
  logic [34:0] exp_rd_q[$];     // {cti, addr}
  logic [66:0] exp_wr_q[$];     // {cti, addr, data}
  logic [63:0] exp_mem_q[$];    // {addr, data}
  int          exp_burst_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_vec = 0;
  int n_err = 0;

  // responder state
  logic [31:0] rsp_dat_q[$];
  int unsigned rsp_due_q[$];
  int unsigned cyc_cnt = 0;
  int          stall_pct = 0;
  int          max_lat = 0;
  logic        hold_vld = 0;
  logic [31:0] hold_addr = 0;
  logic [2:0]  hold_cti = 0;
  logic        prev_cyc = 0;
  int          burst_acc = 0;
  logic        cyc_seen = 0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pipelined memory model; drives stall/ack/data for the coming posedge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      rsp_dat_q.delete();
      rsp_due_q.delete();
      wb_ack_i   = 0;
      wb_stall_i = 0;
      wb_dat_i   = 0;
      hold_vld   = 0;
      prev_cyc   = 0;
      burst_acc  = 0;
    end else begin
      if (hold_vld) begin
        check("stall_stb", 67'(wb_stb_o), 67'(1));
        check("stall_addr", 67'(wb_addr_o), 67'(hold_addr));
        check("stall_cti", 67'(wb_cti_o), 67'(hold_cti));
        hold_vld = 0;
      end
      if (wb_cyc_o) cyc_seen = 1;
      if (prev_cyc && !wb_cyc_o) begin
        if (exp_burst_q.size() == 0) check("burst_extra", 67'(1), 67'(0));
        else check("burst_len", 67'(burst_acc), 67'(exp_burst_q.pop_front()));
        burst_acc = 0;
      end
      prev_cyc = wb_cyc_o;
      wb_stall_i = ($urandom_range(0, 99) < stall_pct);
      if (wb_stb_o && wb_stall_i) begin
        hold_vld  = 1;
        hold_addr = wb_addr_o;
        hold_cti  = wb_cti_o;
      end
      if (wb_stb_o && !wb_stall_i) begin
        burst_acc++;
        check("sel", 67'(wb_sel_o), 67'(4'hf));
        if (!wb_we_o) begin
          if (exp_rd_q.size() == 0) check("rd_extra", 67'(wb_addr_o), 67'(0));
          else check("rd_req", 67'({wb_cti_o, wb_addr_o}), 67'(exp_rd_q.pop_front()));
          rsp_dat_q.push_back(mem.exists(wb_addr_o) ? mem[wb_addr_o] : 32'h0);
        end else begin
          if (exp_wr_q.size() == 0) check("wr_extra", 67'(wb_addr_o), 67'(0));
          else check("wr_req", {wb_cti_o, wb_addr_o, wb_dat_o}, exp_wr_q.pop_front());
          mem[wb_addr_o] = wb_dat_o;
          rsp_dat_q.push_back(32'h0);
        end
        rsp_due_q.push_back(cyc_cnt + 32'($urandom_range(0, max_lat)));
      end
      if (rsp_due_q.size() != 0 && rsp_due_q[0] <= cyc_cnt) begin
        wb_ack_i = 1;
        wb_dat_i = rsp_dat_q.pop_front();
        void'(rsp_due_q.pop_front());
      end else begin
        wb_ack_i = 0;
        wb_dat_i = 32'h0;
      end
      cyc_cnt++;
    end
  end

  // done pulse monitor
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      done_cnt++;
      check("busy_at_done", 67'(busy_o), 67'(0));
    end
  end

  task automatic clear_expect();
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_mem_q.delete();
    exp_burst_q.delete();
  endtask

  // Build expectations for a copy, then pulse start (held for `hold` cycles).
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int hold, output int done_base);
    int rem = len;
    int i = 0;
    int b;
    logic [31:0] a, d;
    logic [2:0] c;
    while (rem > 0) begin
      b = (rem > BL) ? BL : rem;
      for (int p = 0; p < b; p++) begin
        a = src + 32'(4 * (i + p));
        d = dst + 32'(4 * (i + p));
        c = (p == b - 1) ? C_END : C_INCR;
        if (!mem.exists(a)) mem[a] = $urandom;
        exp_rd_q.push_back({c, a});
        exp_wr_q.push_back({c, d, mem[a]});
        exp_mem_q.push_back({d, mem[a]});
      end
      exp_burst_q.push_back(b);
      exp_burst_q.push_back(b);
      i += b;
      rem -= b;
    end
    done_base = done_cnt;
    cyc_seen = 0;
    @(posedge clk_i); #1;
    start_i = 1; src_addr_i = src; dst_addr_i = dst; len_i = 16'(len);
    @(posedge clk_i); #1;
    if (len != 0) check("busy_rise", 67'(busy_o), 67'(1));
    else begin
      check("done_len0", 67'(done_o), 67'(1));
      check("busy_len0", 67'(busy_o), 67'(0));
    end
    for (int h = 1; h < hold; h++) begin
      @(posedge clk_i); #1;
    end
    start_i = 0;
  endtask

  task automatic finish_copy(input int done_base);
    int n = 0;
    logic [63:0] e;
    while (done_cnt == done_base && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 3000) check("done_timeout", 67'(0), 67'(1));
    repeat (4) @(posedge clk_i);
    #1;
    check("done_once", 67'(done_cnt - done_base), 67'(1));
    check("busy_end", 67'(busy_o), 67'(0));
    check("rd_left", 67'(exp_rd_q.size()), 67'(0));
    check("wr_left", 67'(exp_wr_q.size()), 67'(0));
    check("burst_left", 67'(exp_burst_q.size()), 67'(0));
    while (exp_mem_q.size() != 0) begin
      e = exp_mem_q.pop_front();
      check("mem", 67'(mem.exists(e[63:32]) ? mem[e[63:32]] : 32'hx), 67'(e[31:0]));
    end
    clear_expect();
  endtask

  initial begin
    int db;
    int n;
    // reset block
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", 67'(busy_o), 67'(0));
    check("rst_done", 67'(done_o), 67'(0));
    check("rst_bus_ctl", 67'({wb_cyc_o, wb_stb_o, wb_we_o}), 67'(0));
    check("rst_addr", 67'(wb_addr_o), 67'(0));
    check("rst_dat", 67'(wb_dat_o), 67'(0));
    check("rst_sel_cti", 67'({wb_sel_o, wb_cti_o}), 67'(0));
    rst_i = 0;

    // three words, zero-stall zero-latency
    stall_pct = 0; max_lat = 0;
    mem[32'h100] = 32'hA0; mem[32'h104] = 32'hA1; mem[32'h108] = 32'hA2;
    start_copy(32'h100, 32'h200, 3, 1, db);
    finish_copy(db);

    // zero length, start held into the DONE cycle
    start_copy(32'h300, 32'h400, 0, 2, db);
    finish_copy(db);
    check("len0_no_cyc", 67'(cyc_seen), 67'(0));

    // 8/8/4 bursts; a start while busy must be ignored
    stall_pct = 0; max_lat = 1;
    start_copy(32'h1000, 32'h2000, 20, 1, db);
    repeat (10) @(posedge clk_i);
    #1;
    start_i = 1; src_addr_i = 32'h7000; dst_addr_i = 32'h7800; len_i = 16'd5;
    @(posedge clk_i); #1;
    start_i = 0;
    finish_copy(db);

    // random stall and ack latency
    stall_pct = 50; max_lat = 3;
    start_copy(32'h4000, 32'h5000, 17, 1, db);
    finish_copy(db);

    // source range wrapping past 2^32
    stall_pct = 20; max_lat = 2;
    start_copy(32'hFFFF_FFF8, 32'h6000, 4, 1, db);
    finish_copy(db);

    // reset during the second beat of a write burst
    stall_pct = 0; max_lat = 0;
    start_copy(32'h8000, 32'h9000, 3, 1, db);
    n = 0;
    while (!(wb_we_o && wb_stb_o) && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 200) check("wr_phase_timeout", 67'(0), 67'(1));
    @(posedge clk_i); #1;
    rst_i = 1;
    @(posedge clk_i); #1;
    check("rst_mid_cyc_stb", 67'({wb_cyc_o, wb_stb_o}), 67'(0));
    check("rst_mid_busy", 67'(busy_o), 67'(0));
    rst_i = 0;
    clear_expect();
    start_copy(32'hA000, 32'hB000, 2, 1, db);
    finish_copy(db);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
